// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared types and per-element March C- tables for the RAM BIST.
// The element tables return a one-bit background; callers replicate it
// across the data width, so D0 is all zeros and D1 is all ones.

package ram_bist_pkg;

    // Controller states. The address/element advance happens inside the
    // last op cycle of each address, so no separate advance state is held.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_DONE
    } state_e;

    // March C- elements in execution order.
    typedef enum logic [2:0] {
        E0,
        E1,
        E2,
        E3,
        E4,
        E5
    } elem_e;

    localparam elem_e ELEM_LAST = E5;

    // Data backgrounds as single bits, replicated to DW by the user.
    localparam logic BG_D0 = 1'b0;
    localparam logic BG_D1 = 1'b1;

    // Direction: 1 = descending address order.
    function automatic logic elem_down(input elem_e e);
        return (e == E3) || (e == E4) || (e == E5);
    endfunction

    // Elements that start each address with a read.
    function automatic logic elem_has_read(input elem_e e);
        return e != E0;
    endfunction

    // Elements that finish each address with a write.
    function automatic logic elem_has_write(input elem_e e);
        return e != E5;
    endfunction

    // Background the read of this element expects.
    function automatic logic elem_rd_bg(input elem_e e);
        return ((e == E2) || (e == E4)) ? BG_D1 : BG_D0;
    endfunction

    // Background the write of this element stores.
    function automatic logic elem_wr_bg(input elem_e e);
        return ((e == E1) || (e == E3)) ? BG_D1 : BG_D0;
    endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// ram_march_bist_if
// One RAM port as seen by the BIST: write enable, address, write data
// and read data. The BIST is the master; the RAM side is the slave.

interface ram_march_bist_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
// Up/down address counter for the March sequence. A load puts the counter
// at the first address of an element (0 going up, all ones going down);
// a step moves one address in the current direction. The counter never
// relies on overflow to wrap: the controller reloads at element change.

module ram_bist_addr_gen #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    input  logic          down,
    output logic [AW-1:0] addr,
    output logic          last
);

    // Address register: load has priority over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? (addr - AW'(1)) : (addr + AW'(1));
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// ram_march_bist
// March C- built-in self-test initiator for one port of the dual-port RAM.
// Runs E0..E5 over the whole address space, reports pass/fail and keeps
// the address, read data and expected data of the first mismatch.
// Optional build macro RAM_MARCH_BIST_ERRCNT_EN: adds a saturating error
// counter and lets the test run to completion instead of aborting.
// RD_LAT is the RAM read latency, legal range 1..3.

module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [DW-1:0] fail_exp,
`ifdef RAM_MARCH_BIST_ERRCNT_EN
    output logic [7:0]    err_cnt,
`endif
    ram_march_bist_if.master ram
);

`ifdef RAM_MARCH_BIST_ERRCNT_EN
    localparam logic ABORT_ON_FAIL = 1'b0;
`else
    localparam logic ABORT_ON_FAIL = 1'b1;
`endif

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_e        state;
    state_e        state_nxt;
    elem_e         elem;
    elem_e         elem_nxt;
    logic [1:0]    lat_cnt;
    logic [1:0]    lat_nxt;

    logic          ag_load;
    logic          ag_load_down;
    logic          ag_step;
    logic [AW-1:0] addr;
    logic          addr_last;

    logic          advance;
    logic          lat_done;
    logic          mismatch;
    logic          start_run;
    logic [DW-1:0] exp_data;

    ram_bist_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (elem_down(elem)),
        .addr      (addr),
        .last      (addr_last)
    );

    assign lat_done  = (lat_cnt == LAT_LAST);
    assign exp_data  = {DW{elem_rd_bg(elem)}};
    assign mismatch  = (state == S_RD_WAIT) && lat_done && (ram.ram_rdata != exp_data);
    assign start_run = (state == S_IDLE) && start;

    // State, element and latency-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            elem    <= E0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            elem    <= elem_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // Next-state logic; the last op of an address also advances the
    // address or moves to the next element so there is no idle bubble.
    always_comb begin
        state_nxt    = state;
        elem_nxt     = elem;
        lat_nxt      = lat_cnt;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        advance      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_WRITE;
                    elem_nxt     = E0;
                    ag_load      = 1'b1;
                    ag_load_down = elem_down(E0);
                end
            end
            S_WRITE: begin
                advance = 1'b1;
            end
            S_RD_ISSUE: begin
                lat_nxt   = '0;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (!lat_done) begin
                    lat_nxt = lat_cnt + 2'd1;
                end else if (mismatch && ABORT_ON_FAIL) begin
                    state_nxt = S_DONE;
                end else if (elem_has_write(elem)) begin
                    state_nxt = S_WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (advance) begin
            if (!addr_last) begin
                ag_step   = 1'b1;
                state_nxt = elem_has_read(elem) ? S_RD_ISSUE : S_WRITE;
            end else if (elem == ELEM_LAST) begin
                state_nxt = S_DONE;
            end else begin
                elem_nxt     = elem_e'(elem + 3'd1);
                ag_load      = 1'b1;
                ag_load_down = elem_down(elem_nxt);
                state_nxt    = elem_has_read(elem_nxt) ? S_RD_ISSUE : S_WRITE;
            end
        end
    end

    // Result registers: cleared on start, first mismatch captured while
    // pass is still high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass      <= 1'b1;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
        end else if (start_run) begin
            pass      <= 1'b1;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
        end else if (mismatch && pass) begin
            pass      <= 1'b0;
            fail_addr <= addr;
            fail_data <= ram.ram_rdata;
            fail_exp  <= exp_data;
        end
    end

`ifdef RAM_MARCH_BIST_ERRCNT_EN
    // Saturating mismatch counter, cleared when a run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (start_run) begin
            err_cnt <= '0;
        end else if (mismatch && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    // RAM port drive, decoded from state so reset clears it immediately.
    always_comb begin
        ram.ram_we    = (state == S_WRITE);
        ram.ram_addr  = '0;
        ram.ram_wdata = '0;
        if ((state == S_WRITE) || (state == S_RD_ISSUE) || (state == S_RD_WAIT)) begin
            ram.ram_addr = addr;
        end
        if (state == S_WRITE) begin
            ram.ram_wdata = {DW{elem_wr_bg(elem)}};
        end
    end

    assign busy = (state == S_WRITE) || (state == S_RD_ISSUE) || (state == S_RD_WAIT);
    assign done = (state == S_DONE);

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator that drives one port of the team's dual-port RAM (`dual`) through its clk/we/data/addr/dout interface.
- Runs a March C- algorithm over the whole address space and reports pass/fail with first-failure details.
- Sits beside the RAM. A mux outside this block hands the RAM port to the BIST while busy=1.

Parameters:
- AW, 6, address width; depth = 2**AW.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency: cycles from address presented (we=0) to dout valid. Legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- busy  out  1  high while a test runs.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  result of last test; held until next start.
- ram_we  out  1  write enable to RAM port.
- ram_addr  out  AW  address to RAM port.
- ram_wdata  out  DW  write data to RAM port.
- ram_rdata  in  DW  read data from RAM port.
- fail_addr  out  AW  address of first mismatch.
- fail_data  out  DW  data read at first mismatch.
- fail_exp  out  DW  expected data at first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, except pass, which resets to 1.
- Data backgrounds: D0 = all zeros, D1 = all ones.
- March elements, in order:
  - E0 ⇑(w D0)
  - E1 ⇑(r D0, w D1)
  - E2 ⇑(r D1, w D0)
  - E3 ⇓(r D0, w D1)
  - E4 ⇓(r D1, w D0)
  - E5 ⇓(r D0)
- ⇑ runs address 0 to 2**AW-1; ⇓ runs 2**AW-1 to 0. The address counter wraps only by reloading at element change, never by overflow.
- Op timing:
  - Write = 1 cycle: ram_we=1, addr and wdata valid.
  - Read = 1 issue cycle (ram_we=0, addr valid) + RD_LAT wait cycles. ram_rdata is compared in the last wait cycle.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT (latency counter), NEXT (address/element advance, combined into the last op cycle, so no bubble), DONE.
- Start handling:
  - start=1 in IDLE → busy=1 and pass=1 from the next cycle. fail_* are cleared to 0.
  - start while busy is ignored.
- Cycle count, with N = 2**AW:
  - busy stays high for N + 4·N·(2+RD_LAT) + N·(1+RD_LAT) cycles.
  - AW=6, RD_LAT=1: 960 cycles.
- Completion: done pulses in the cycle after the last op, with busy=0 in the same cycle. Back to IDLE.
- Mismatch, default build:
  - pass←0; fail_addr/data/exp captured.
  - Test aborts; done pulses the next cycle.
  - Remaining ops are not issued, so RAM contents are left partially written.
- Outside WRITE, ram_we=0. In IDLE, ram_addr and ram_wdata hold 0.
- Reset mid-test: immediate return to IDLE, ram_we deasserted asynchronously, no done pulse.

Optional Feature:
- Macro: RAM_MARCH_BIST_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], which saturates at 255 and is cleared on start.
  - A mismatch does not abort. The test runs to completion.
  - fail_* still hold the first mismatch only.
  - busy length always equals the full cycle count.
- Undefined: err_cnt port absent; abort-on-first-fail as above.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum
  - element encoding (E0..E5)
  - per-element tables: direction, read-expected background, write background, has-read, has-write
  - D0/D1 constants
- One natural sub-module: ram_bist_addr_gen, an up/down address counter with load-start, step and last-address flag. Everything else stays in the top FSM.

Test Plan:
- Fault-free 64×8 RAM model, RD_LAT=1: start pulse → busy for exactly 960 cycles, done pulse once, pass=1, fail_*=0; final RAM contents all 0x00.
- Stuck-at-1 on bit 3 at address 0x05: start → pass=0, fail_addr=0x05, fail_exp=0x00, fail_data=0x08; done in the cycle after the E1 read compare of address 5.
- Coupling fault (a write of 0xFF to address 0x06 flips address 0x05 to 0xFF): start → fail detected in E3 (down pass) at fail_addr=0x05, fail_exp=0x00, fail_data=0xFF.
- start asserted again at cycle 100 of a run, then rst_n pulled low at cycle 200 → the second start has no effect; on reset, outputs return to reset values asynchronously and no done appears; a fresh start afterwards runs the full 960 cycles.
- RD_LAT=2 fault-free → busy length 64+4·64·4+64·3 = 1280 cycles, pass=1.
- With RAM_MARCH_BIST_ERRCNT_EN and bit 3 stuck-at-1 at address 0x05 → full 960-cycle run, err_cnt=3 (E1, E3 and E5 reads of address 5), fail_addr=0x05.
